// File: rtl/peripheral_bus.sv
// peripheral_bus: memory-mapped timer, LED, 7-seg and SysTick registers
// on the MEM-stage data bus, plus the registered timer interrupt request.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-low reset
//   MemRead    load in MEM stage
//   MemWrite   store in MEM stage
//   Address    byte address from the ALU (bits 1:0 ignored)
//   Write_data store data, truncated to the target register width
//   Read_data  selected register, zero-extended; 0 when no read hit
//   Hit        Address lies inside the 6-word register window
//   irq_out    timer interrupt request (TCON[2])
//   leds       LED register
//   digi       7-seg register {anode[3:0], seg[7:0]}
module peripheral_bus #(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
    parameter int          LED_W     = 8,
    parameter int          DIGI_W    = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [31:0]       Address,
    input  logic [31:0]       Write_data,
    output logic [31:0]       Read_data,
    output logic              Hit,
    output logic              irq_out,
    output logic [LED_W-1:0]  leds,
    output logic [DIGI_W-1:0] digi
);

    localparam logic [2:0] IDX_TH   = 3'd0;
    localparam logic [2:0] IDX_TL   = 3'd1;
    localparam logic [2:0] IDX_TCON = 3'd2;
    localparam logic [2:0] IDX_LED  = 3'd3;
    localparam logic [2:0] IDX_DIGI = 3'd4;
    localparam logic [2:0] IDX_SYST = 3'd5;

    logic [31:0]       th_q;
    logic [31:0]       tl_q;
    logic [2:0]        tcon_q;
    logic [LED_W-1:0]  led_q;
    logic [DIGI_W-1:0] digi_q;
    logic [31:0]       syst_q;

    logic [2:0] idx;
    logic       in_page;
    logic       wr;
    logic       sel_th;
    logic       sel_tl;
    logic       sel_tcon;
    logic       sel_led;
    logic       sel_digi;
    logic       sel_syst;
    logic       ovf;
    logic       irq_set;

    logic [1:0] unused_addr_lsb;

    assign unused_addr_lsb = Address[1:0];

    // ------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------
    assign idx     = Address[4:2];
    assign in_page = (Address[31:5] == BASE_ADDR[31:5]);
    assign Hit     = in_page && (idx <= IDX_SYST);
    assign wr      = MemWrite && Hit;

    assign sel_th   = Hit && (idx == IDX_TH);
    assign sel_tl   = Hit && (idx == IDX_TL);
    assign sel_tcon = Hit && (idx == IDX_TCON);
    assign sel_led  = Hit && (idx == IDX_LED);
    assign sel_digi = Hit && (idx == IDX_DIGI);
    assign sel_syst = Hit && (idx == IDX_SYST);

    // ------------------------------------------------------------
    // Timer overflow: enabled and at all-ones this cycle
    // ------------------------------------------------------------
    assign ovf     = tcon_q[0] && (tl_q == 32'hFFFF_FFFF);
    assign irq_set = ovf && tcon_q[1];

    // ------------------------------------------------------------
    // Timer reload register
    // ------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            th_q <= 32'h0;
        end else if (wr && sel_th) begin
            th_q <= Write_data;
        end
    end

    // ------------------------------------------------------------
    // Timer count: a CPU write beats both increment and reload.
    // Reload takes the TH value from before any same-cycle TH write.
    // ------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tl_q <= 32'h0;
        end else if (wr && sel_tl) begin
            tl_q <= Write_data;
        end else if (ovf) begin
            tl_q <= th_q;
        end else if (tcon_q[0]) begin
            tl_q <= tl_q + 32'd1;
        end
    end

    // ------------------------------------------------------------
    // Timer control. Status bit 2 is sticky: an overflow set wins
    // over a same-cycle CPU clear.
    // ------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tcon_q <= 3'b000;
        end else if (wr && sel_tcon) begin
            tcon_q[1:0] <= Write_data[1:0];
            tcon_q[2]   <= Write_data[2] | irq_set;
        end else if (irq_set) begin
            tcon_q[2] <= 1'b1;
        end
    end

    // ------------------------------------------------------------
    // LED and 7-seg registers
    // ------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            led_q <= '0;
        end else if (wr && sel_led) begin
            led_q <= Write_data[LED_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            digi_q <= '0;
        end else if (wr && sel_digi) begin
            digi_q <= Write_data[DIGI_W-1:0];
        end
    end

    // ------------------------------------------------------------
    // Free-running cycle counter; read-only, wraps naturally
    // ------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            syst_q <= 32'h0;
        end else begin
            syst_q <= syst_q + 32'd1;
        end
    end

    // ------------------------------------------------------------
    // Combinational read mux; returns pre-write values on a
    // simultaneous read and write.
    // ------------------------------------------------------------
    always_comb begin
        Read_data = 32'h0;
        if (MemRead) begin
            unique case (1'b1)
                sel_th:   Read_data = th_q;
                sel_tl:   Read_data = tl_q;
                sel_tcon: Read_data = {29'h0, tcon_q};
                sel_led:  Read_data = {{(32-LED_W){1'b0}}, led_q};
                sel_digi: Read_data = {{(32-DIGI_W){1'b0}}, digi_q};
                sel_syst: Read_data = syst_q;
                default:  Read_data = 32'h0;
            endcase
        end
    end

    // ------------------------------------------------------------
    // Outputs straight from state
    // ------------------------------------------------------------
    assign irq_out = tcon_q[2];
    assign leds    = led_q;
    assign digi    = digi_q;

endmodule

// File: tb/tb_peripheral_bus.sv
// tb_peripheral_bus: directed-vector self-checking bench for
// peripheral_bus (reset, timer/IRQ, decode, collisions, async reset).
module tb_peripheral_bus;

    localparam logic [31:0] A_TH   = 32'h4000_0000;
    localparam logic [31:0] A_TL   = 32'h4000_0004;
    localparam logic [31:0] A_TCON = 32'h4000_0008;
    localparam logic [31:0] A_LED  = 32'h4000_000C;
    localparam logic [31:0] A_DIGI = 32'h4000_0010;
    localparam logic [31:0] A_SYST = 32'h4000_0014;

    logic        clk;
    logic        reset;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] Address;
    logic [31:0] Write_data;
    logic [31:0] Read_data;
    logic        Hit;
    logic        irq_out;
    logic [7:0]  leds;
    logic [11:0] digi;

    int n_cmp;
    int n_err;

    logic [31:0] rd;

    peripheral_bus #(
        .BASE_ADDR (32'h4000_0000),
        .LED_W     (8),
        .DIGI_W    (12)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .Address    (Address),
        .Write_data (Write_data),
        .Read_data  (Read_data),
        .Hit        (Hit),
        .irq_out    (irq_out),
        .leds       (leds),
        .digi       (digi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Store: set up after a falling edge, commit at the next rising edge,
    // return 1ns after that edge.
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        Address    = a;
        Write_data = d;
        MemWrite   = 1'b1;
        @(posedge clk);
        #1;
        MemWrite   = 1'b0;
        Write_data = 32'h0;
    endtask

    // Combinational load between edges; does not consume a clock.
    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        Address = a;
        MemRead = 1'b1;
        #1;
        d = Read_data;
        MemRead = 1'b0;
    endtask

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        reset      = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        Address    = 32'h0;
        Write_data = 32'h0;

        // 1: reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_irq", {31'h0, irq_out}, 32'h0);
        chk("rst_leds", {24'h0, leds}, 32'h0);
        chk("rst_digi", {20'h0, digi}, 32'h0);
        chk("rst_rdata", Read_data, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        bus_read(A_SYST, rd);
        chk("rst_syst", rd, 32'd2);
        bus_read(A_TL, rd);
        chk("rst_tl", rd, 32'h0);

        // 2: timer IRQ
        bus_write(A_TH, 32'hFFFF_FFFC);
        bus_write(A_TL, 32'hFFFF_FFFC);
        bus_write(A_TCON, 32'h3);
        chk("tmr_irq0", {31'h0, irq_out}, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        bus_read(A_TL, rd);
        chk("tmr_tl_max", rd, 32'hFFFF_FFFF);
        chk("tmr_irq_pre", {31'h0, irq_out}, 32'h0);
        @(posedge clk);
        #1;
        chk("tmr_irq_rise", {31'h0, irq_out}, 32'h1);
        bus_read(A_TL, rd);
        chk("tmr_reload", rd, 32'hFFFF_FFFC);
        bus_read(A_TCON, rd);
        chk("tmr_tcon7", rd, 32'h7);
        bus_write(A_TCON, 32'h3);
        chk("tmr_irq_clr", {31'h0, irq_out}, 32'h0);

        // 3: disabled timer
        bus_write(A_TCON, 32'h2);
        bus_write(A_TL, 32'h5);
        repeat (100) @(posedge clk);
        #1;
        bus_read(A_TL, rd);
        chk("dis_tl", rd, 32'h5);
        chk("dis_irq", {31'h0, irq_out}, 32'h0);
        bus_read(A_TCON, rd);
        chk("dis_tcon", rd, 32'h2);

        // 4: decode
        bus_write(A_LED, 32'hFFFF_FFA5);
        chk("dec_leds", {24'h0, leds}, 32'hA5);
        Address = A_LED;
        #1;
        chk("dec_hit_led", {31'h0, Hit}, 32'h1);
        bus_read(A_LED, rd);
        chk("dec_rd_led", rd, 32'hA5);
        bus_write(A_DIGI, 32'h1234_5ABC);
        chk("dec_digi", {20'h0, digi}, 32'hABC);
        Address = 32'h4000_0018;
        #1;
        chk("dec_hit_18", {31'h0, Hit}, 32'h0);
        bus_read(32'h4000_0018, rd);
        chk("dec_rd_18", rd, 32'h0);
        Address = 32'h0000_000C;
        #1;
        chk("dec_hit_0c", {31'h0, Hit}, 32'h0);
        bus_read(32'h0000_000C, rd);
        chk("dec_rd_0c", rd, 32'h0);
        bus_write(A_SYST, 32'h0);
        bus_read(A_SYST, rd);
        chk("dec_syst_ro", {31'h0, (rd > 32'd100)}, 32'h1);

        // 5: TCON write collides with overflow; set beats clear
        bus_write(A_TH, 32'h10);
        bus_write(A_TL, 32'hFFFF_FFFE);
        bus_write(A_TCON, 32'h3);
        @(posedge clk);
        bus_write(A_TCON, 32'h3);
        bus_read(A_TCON, rd);
        chk("col_tcon", rd, 32'h7);
        chk("col_irq", {31'h0, irq_out}, 32'h1);
        bus_read(A_TL, rd);
        chk("col_tl", rd, 32'h10);

        // 6: async reset between edges
        bus_write(A_TL, 32'd1234);
        bus_read(A_TL, rd);
        chk("ar_tl_pre", rd, 32'd1234);
        reset = 1'b0;
        #1;
        bus_read(A_TL, rd);
        chk("ar_tl", rd, 32'h0);
        chk("ar_irq", {31'h0, irq_out}, 32'h0);
        chk("ar_leds", {24'h0, leds}, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("ar_irq_quiet", {31'h0, irq_out}, 32'h0);
        bus_read(A_TL, rd);
        chk("ar_tl_hold", rd, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
